dsp_mac_slice: RTL

//  Parametrised signed multiply-accumulate slice; next generation of our DSP48A1-style slice.

---
 rtl/dsp_pkg.sv | 26 ++
 rtl/dsp_pipe.sv | 32 +++
 rtl/dsp_mac_slice.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared OPMODE bit positions and X/Z multiplexer select encodings for the MAC slice.
package dsp_pkg;

    localparam int unsigned OPMODE_W    = 8;
    localparam int unsigned OP_X_LSB    = 0;
    localparam int unsigned OP_Z_LSB    = 2;
    localparam int unsigned OP_PRE_EN   = 4;
    localparam int unsigned OP_PRE_SUB  = 5;
    localparam int unsigned OP_POST_SUB = 6;
    localparam int unsigned OP_CIN      = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_RSVD = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

endpackage

// File: rtl/dsp_pipe.sv
// Clock-enabled delay line with synchronous reset; DEPTH=0 collapses to a wire.
module dsp_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_q = i_d;
        end else begin : g_reg
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
                end else if (i_ce) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_slice.sv
// Signed pre-add / multiply / post-add accumulator slice with valid tracking,
// optional saturation, overflow/underflow flags and pattern detect.
module dsp_mac_slice
    import dsp_pkg::*;
#(
    parameter int unsigned        A_WIDTH  = 18,
    parameter int unsigned        B_WIDTH  = 18,
    parameter int unsigned        P_WIDTH  = 48,
    parameter int unsigned        IREG     = 1,
    parameter int unsigned        MREG     = 1,
    parameter bit                 SATURATE = 1'b0,
    parameter logic [P_WIDTH-1:0] PATTERN  = '0,
    parameter logic [P_WIDTH-1:0] MASK     = '1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ce,
    input  logic                i_in_valid,
    input  logic [A_WIDTH-1:0]  i_a,
    input  logic [B_WIDTH-1:0]  i_b,
    input  logic [B_WIDTH-1:0]  i_d,
    input  logic [P_WIDTH-1:0]  i_c,
    input  logic [P_WIDTH-1:0]  i_pcin,
    input  logic [OPMODE_W-1:0] i_opmode,
    output logic [B_WIDTH-1:0]  o_bcout,
    output logic [P_WIDTH-1:0]  o_p,
    output logic [P_WIDTH-1:0]  o_pcout,
    output logic                o_out_valid,
    output logic                o_overflow,
    output logic                o_underflow,
    output logic                o_pattern_detect
);

    localparam int unsigned M_WIDTH = A_WIDTH + B_WIDTH + 1;
    localparam int unsigned R_WIDTH = P_WIDTH + 2;
    localparam int unsigned S1_W    = 1 + OPMODE_W + A_WIDTH + 2 * B_WIDTH;
    localparam int unsigned S2_W    = 7 + M_WIDTH;

    localparam logic signed [R_WIDTH-1:0] R_MAX = {3'b000, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [R_WIDTH-1:0] R_MIN = {3'b111, {(P_WIDTH-1){1'b0}}};
    localparam logic [P_WIDTH-1:0]        P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0]        P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    logic [S1_W-1:0]            w_s1_bus;
    logic                       w_s1_valid;
    logic [OPMODE_W-1:0]        w_s1_op;
    logic signed [A_WIDTH-1:0]  w_s1_a;
    logic signed [B_WIDTH-1:0]  w_s1_b;
    logic signed [B_WIDTH-1:0]  w_s1_d;
    logic signed [B_WIDTH:0]    w_b_x;
    logic signed [B_WIDTH:0]    w_d_x;
    logic signed [B_WIDTH:0]    w_bp;
    logic signed [M_WIDTH-1:0]  w_m;

    logic [S2_W-1:0]            w_s2_bus;
    logic                       w_s2_valid;
    logic                       w_s2_cin;
    logic                       w_s2_sub;
    logic [1:0]                 w_s2_zsel;
    logic [1:0]                 w_s2_xsel;
    logic signed [M_WIDTH-1:0]  w_s2_m;

    logic signed [R_WIDTH-1:0]  w_x;
    logic signed [R_WIDTH-1:0]  w_z;
    logic signed [R_WIDTH-1:0]  w_r;
    logic                       w_ovf;
    logic                       w_unf;
    logic [P_WIDTH-1:0]         w_p_next;
    logic                       w_pdet;

    logic signed [P_WIDTH-1:0]  r_p;
    logic                       r_out_valid;
    logic                       r_ovf;
    logic                       r_unf;
    logic                       r_pdet;

    // Input stage: operands, mode and valid travel together
    dsp_pipe #(.WIDTH(S1_W), .DEPTH(IREG)) u_in_pipe (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_ce  (i_ce),
        .i_d   ({i_in_valid, i_opmode, i_a, i_b, i_d}),
        .o_q   (w_s1_bus)
    );

    assign {w_s1_valid, w_s1_op, w_s1_a, w_s1_b, w_s1_d} = w_s1_bus;

    // Pre-adder is one bit wider than B so D+/-B never wraps
    always_comb begin
        w_b_x = {w_s1_b[B_WIDTH-1], w_s1_b};
        w_d_x = {w_s1_d[B_WIDTH-1], w_s1_d};
        w_bp  = w_b_x;
        if (w_s1_op[OP_PRE_EN]) begin
            w_bp = w_s1_op[OP_PRE_SUB] ? (w_d_x - w_b_x) : (w_d_x + w_b_x);
        end
    end

    assign w_m = M_WIDTH'(w_s1_a) * M_WIDTH'(w_bp);

    // Only the post-adder controls are carried past the multiplier
    dsp_pipe #(.WIDTH(S2_W), .DEPTH(MREG)) u_m_pipe (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_ce  (i_ce),
        .i_d   ({w_s1_valid, w_s1_op[OP_CIN], w_s1_op[OP_POST_SUB],
                 w_s1_op[OP_Z_LSB +: 2], w_s1_op[OP_X_LSB +: 2], w_m}),
        .o_q   (w_s2_bus)
    );

    assign {w_s2_valid, w_s2_cin, w_s2_sub, w_s2_zsel, w_s2_xsel, w_s2_m} = w_s2_bus;

    // Post-adder at two guard bits so overflow can be seen before clamping
    always_comb begin
        w_x = '0;
        case (x_sel_e'(w_s2_xsel))
            X_M:     w_x = R_WIDTH'(w_s2_m);
            X_P:     w_x = R_WIDTH'(r_p);
            default: w_x = '0;
        endcase

        w_z = '0;
        case (z_sel_e'(w_s2_zsel))
            Z_PCIN:  w_z = R_WIDTH'($signed(i_pcin));
            Z_P:     w_z = R_WIDTH'(r_p);
            Z_C:     w_z = R_WIDTH'($signed(i_c));
            default: w_z = '0;
        endcase

        w_r = w_s2_sub ? (w_z - (w_x + R_WIDTH'(w_s2_cin)))
                       : (w_z + w_x + R_WIDTH'(w_s2_cin));

        w_ovf    = (w_r > R_MAX);
        w_unf    = (w_r < R_MIN);
        w_p_next = w_r[P_WIDTH-1:0];
        if (SATURATE && w_ovf) w_p_next = P_MAX;
        if (SATURATE && w_unf) w_p_next = P_MIN;

        w_pdet = (((w_p_next ^ PATTERN) & MASK) == '0);
    end

    // Result registers load only for valid items, so P holds across bubbles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p         <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_pdet      <= 1'b0;
        end else begin
            r_out_valid <= i_ce & w_s2_valid;
            if (i_ce && w_s2_valid) begin
                r_p    <= w_p_next;
                r_ovf  <= w_ovf;
                r_unf  <= w_unf;
                r_pdet <= w_pdet;
            end
        end
    end

    assign o_bcout          = w_s1_b;
    assign o_p              = r_p;
    assign o_pcout          = r_p;
    assign o_out_valid      = r_out_valid;
    assign o_overflow       = r_ovf;
    assign o_underflow      = r_unf;
    assign o_pattern_detect = r_pdet;

endmodule
